// File: rtl/apb_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter_if
//
// Bundles every non-clock, non-reset signal of apb_req_arbiter.
//
// Requester side (4 requesters, requester i owns slice i of each vector):
//   req_valid[4], req_write[4], req_psel[8], req_addr[4*AW], req_wdata[4*DW]
//   req_done[4] (one-hot completion pulse), req_err, rdata, grant_id, busy
// APB master command side:
//   t_valid, pwrite_in, psel_in[2], paddr_in, pwdata_in   (arbiter -> master)
//   m_ready                                               (master -> arbiter)
// APB bus observation:
//   penable, pready, prdata                               (bus -> arbiter)
//
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters + APB master + bus)
// ---------------------------------------------------------------------------
interface apb_req_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    // Requester side
    logic [3:0]              req_valid;
    logic [3:0]              req_write;
    logic [7:0]              req_psel;
    logic [4*ADDR_WIDTH-1:0] req_addr;
    logic [4*DATA_WIDTH-1:0] req_wdata;
    logic [3:0]              req_done;
    logic                    req_err;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              grant_id;
    logic                    busy;

    // APB master command side
    logic                    t_valid;
    logic                    pwrite_in;
    logic [1:0]              psel_in;
    logic [ADDR_WIDTH-1:0]   paddr_in;
    logic [DATA_WIDTH-1:0]   pwdata_in;
    logic                    m_ready;

    // APB bus observation
    logic                    penable;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;

    modport slave (
        input  req_valid, req_write, req_psel, req_addr, req_wdata,
        input  m_ready, penable, pready, prdata,
        output req_done, req_err, rdata, grant_id, busy,
        output t_valid, pwrite_in, psel_in, paddr_in, pwdata_in
    );

    modport master (
        output req_valid, req_write, req_psel, req_addr, req_wdata,
        output m_ready, penable, pready, prdata,
        input  req_done, req_err, rdata, grant_id, busy,
        input  t_valid, pwrite_in, psel_in, paddr_in, pwdata_in
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
//
// Arbitrates four requesters onto a single APB master. In IDLE a winner is
// chosen, its command fields are latched, and the transfer is handed to the
// APB master through t_valid / m_ready. Completion (penable && pready) is
// reported back to the winner with a one-cycle one-hot req_done pulse.
// A winner with slave select 2'b00 is rejected straight away with req_err.
//
// Ports:
//   pclk  - clock, all state changes on the rising edge
//   prst  - asynchronous, active-low reset
//   bus   - apb_req_arbiter_if.slave (requester, command and bus signals)
//
// Parameters:
//   DATA_WIDTH - requester / APB data width (default 16)
//   ADDR_WIDTH - requester / APB address width (default 4)
//
// Build option:
//   APB_ARB_FIXED_PRIO_EN - when defined, fixed priority (requester 0 highest);
//                           otherwise round-robin from (last grant + 1) mod 4.
// ---------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic             pclk,
    input  logic             prst,
    apb_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_reg;
    logic [1:0]              grant_id_reg;
    logic                    pwrite_reg;
    logic [1:0]              psel_reg;
    logic [ADDR_WIDTH-1:0]   paddr_reg;
    logic [DATA_WIDTH-1:0]   pwdata_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic [3:0]              req_done_reg;
    logic                    req_err_reg;
    logic                    t_valid_reg;
`ifndef APB_ARB_FIXED_PRIO_EN
    logic [1:0]              rr_ptr_reg;   // last granted requester
`endif

    // Per-requester views of the packed request vectors
    logic [ADDR_WIDTH-1:0]   addr_slice  [4];
    logic [DATA_WIDTH-1:0]   wdata_slice [4];
    logic [1:0]              psel_slice  [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            assign addr_slice[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_slice[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign psel_slice[gi]  = bus.req_psel[2*gi +: 2];
        end
    endgenerate

    // Winner selection. Iterating from lowest to highest priority and letting
    // later matches overwrite earlier ones leaves the highest-priority
    // requester in winner_idx.
    logic       winner_found;
    logic [1:0] winner_idx;

    always_comb begin
        winner_found = 1'b0;
        winner_idx   = 2'd0;
`ifdef APB_ARB_FIXED_PRIO_EN
        for (int k = 3; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                winner_found = 1'b1;
                winner_idx   = 2'(k);
            end
        end
`else
        // Offset 1 (the requester after the last grant) is the highest
        // priority, offset 4 (the last grant itself) the lowest.
        for (int k = 4; k >= 1; k--) begin
            if (bus.req_valid[rr_ptr_reg + 2'(k)]) begin
                winner_found = 1'b1;
                winner_idx   = rr_ptr_reg + 2'(k);
            end
        end
`endif
    end

    logic xfer_fire;
    assign xfer_fire = bus.penable && bus.pready;

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state_reg    <= IDLE;
            grant_id_reg <= 2'd0;
            pwrite_reg   <= 1'b0;
            psel_reg     <= 2'b00;
            paddr_reg    <= '0;
            pwdata_reg   <= '0;
            rdata_reg    <= '0;
            req_done_reg <= 4'b0000;
            req_err_reg  <= 1'b0;
            t_valid_reg  <= 1'b0;
`ifndef APB_ARB_FIXED_PRIO_EN
            rr_ptr_reg   <= 2'd3;   // requester 0 wins the first round
`endif
        end else begin
            // Completion flags are single-cycle pulses
            req_done_reg <= 4'b0000;
            req_err_reg  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (winner_found) begin
                        grant_id_reg <= winner_idx;
                        pwrite_reg   <= bus.req_write[winner_idx];
                        psel_reg     <= psel_slice[winner_idx];
                        paddr_reg    <= addr_slice[winner_idx];
                        pwdata_reg   <= wdata_slice[winner_idx];
`ifndef APB_ARB_FIXED_PRIO_EN
                        rr_ptr_reg   <= winner_idx;
`endif
                        if (psel_slice[winner_idx] == 2'b00) begin
                            // No slave selected: reject without touching the bus
                            state_reg    <= DONE;
                            req_done_reg <= 4'b0001 << winner_idx;
                            req_err_reg  <= 1'b1;
                        end else begin
                            state_reg   <= ISSUE;
                            t_valid_reg <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    if (bus.m_ready) begin
                        t_valid_reg <= 1'b0;
                        // m_ready marks the first ACCESS cycle, so a zero
                        // wait-state slave completes in this same cycle.
                        if (xfer_fire) begin
                            if (!pwrite_reg) begin
                                rdata_reg <= bus.prdata;
                            end
                            req_done_reg <= 4'b0001 << grant_id_reg;
                            state_reg    <= DONE;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    // No timeout: a slave may stretch ACCESS indefinitely
                    if (xfer_fire) begin
                        if (!pwrite_reg) begin
                            rdata_reg <= bus.prdata;
                        end
                        req_done_reg <= 4'b0001 << grant_id_reg;
                        state_reg    <= DONE;
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // t_valid drops combinationally as soon as the master accepts
    assign bus.t_valid   = t_valid_reg & ~bus.m_ready;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.req_done  = req_done_reg;
    assign bus.req_err   = req_err_reg;
    assign bus.rdata     = rdata_reg;
    assign bus.grant_id  = grant_id_reg;
    assign bus.pwrite_in = pwrite_reg;
    assign bus.psel_in   = psel_reg;
    assign bus.paddr_in  = paddr_reg;
    assign bus.pwdata_in = pwdata_reg;

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;

    localparam int DW = 16;
    localparam int AW = 4;

    logic pclk = 1'b0;
    logic prst = 1'b0;

    apb_req_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    apb_req_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .pclk (pclk),
        .prst (prst),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    int errors = 0;
    int checks = 0;

    // Reference model state: last granted requester and last read data
    int              m_ptr   = 3;
    logic [DW-1:0]   m_rdata = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Winner according to the arbitration rule, from the request mask alone
    function automatic int model_pick(input logic [3:0] v);
        int w;
        w = -1;
`ifdef APB_ARB_FIXED_PRIO_EN
        for (int i = 3; i >= 0; i--) if (v[i]) w = i;
`else
        for (int off = 4; off >= 1; off--) if (v[(m_ptr + off) % 4]) w = (m_ptr + off) % 4;
`endif
        return w;
    endfunction

    task automatic set_req(input int i, input logic wr, input logic [1:0] ps,
                           input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        bus.req_write[i]          = wr;
        bus.req_psel[2*i +: 2]    = ps;
        bus.req_addr[i*AW +: AW]  = ad;
        bus.req_wdata[i*DW +: DW] = wd;
    endtask

    task automatic apb_idle();
        bus.m_ready = 1'b0;
        bus.penable = 1'b0;
        bus.pready  = 1'b0;
        bus.prdata  = '0;
    endtask

    // One full arbitration round. Called at a falling edge with the DUT in
    // IDLE and the request inputs already driven. Plays the APB master,
    // then checks completion against the model.
    task automatic do_txn(input string tag, input int delay, input logic [DW-1:0] prd,
                          input bit scramble);
        int              w, phase, left, t_at, p_at, d_at;
        bit              got, saw_tv, tv_late;
        logic            e_wr, e_err;
        logic [1:0]      e_ps;
        logic [AW-1:0]   e_ad;
        logic [DW-1:0]   e_wd;
        logic [3:0]      o_done;
        logic            o_err, o_busy, o_wr;
        logic [1:0]      o_gid, o_ps;
        logic [AW-1:0]   o_ad;
        logic [DW-1:0]   o_rd, o_wd;

        w = model_pick(bus.req_valid);
        if (w < 0) w = 0;
        m_ptr = w;
        e_wr  = bus.req_write[w];
        e_ps  = bus.req_psel[2*w +: 2];
        e_ad  = bus.req_addr[w*AW +: AW];
        e_wd  = bus.req_wdata[w*DW +: DW];
        e_err = (e_ps == 2'b00);

        phase = 0; left = 0; t_at = -1; p_at = -1; d_at = -1;
        got = 0; saw_tv = 0; tv_late = 0;
        o_done = '0; o_err = 0; o_busy = 0; o_gid = '0; o_rd = '0;
        o_wr = 0; o_ps = '0; o_ad = '0; o_wd = '0;

        for (int n = 1; n <= 64 && !got; n++) begin
            @(negedge pclk);
            if (bus.req_done != 4'b0000) begin
                got = 1; d_at = n;
                o_done = bus.req_done; o_err = bus.req_err; o_busy = bus.busy;
                o_gid = bus.grant_id; o_rd = bus.rdata;
                o_wr = bus.pwrite_in; o_ps = bus.psel_in; o_ad = bus.paddr_in; o_wd = bus.pwdata_in;
            end else if (phase == 0) begin
                if (bus.t_valid) begin
                    saw_tv = 1; t_at = n;
                    bus.m_ready = 1'b1;
                    bus.penable = 1'b1;
                    bus.prdata  = prd;
                    left        = delay;
                    bus.pready  = (delay == 0);
                    if (delay == 0) p_at = n;
                    if (scramble) begin
                        bus.req_write = 4'($urandom);
                        bus.req_psel  = 8'($urandom);
                        bus.req_addr  = (4*AW)'($urandom);
                        bus.req_wdata = {$urandom, $urandom};
                    end
                    phase = 1;
                    #1 check({tag, " tvalid_drop"}, 32'(bus.t_valid), 32'd0);
                end
            end else begin
                if (bus.t_valid) tv_late = 1;
                bus.m_ready = 1'b0;
                if (left > 0) left--;
                bus.pready = (left == 0);
                if (left == 0 && p_at < 0) p_at = n;
            end
        end
        apb_idle();

        check({tag, " timeout"}, 32'(got), 32'd1);
        check({tag, " req_done"}, 32'(o_done), 32'(4'b0001 << w));
        check({tag, " req_err"}, 32'(o_err), 32'(e_err));
        check({tag, " grant_id"}, 32'(o_gid), 32'(w));
        check({tag, " busy_done"}, 32'(o_busy), 32'd1);
        check({tag, " tvalid_seen"}, 32'(saw_tv), 32'(!e_err));
        if (!e_wr && !e_err) m_rdata = prd;
        check({tag, " rdata"}, 32'(o_rd), 32'(m_rdata));
        if (e_err) begin
            check({tag, " err_latency"}, 32'(d_at >= 1 && d_at <= 2), 32'd1);
        end else begin
            check({tag, " grant_to_tvalid"}, 32'(t_at), 32'd1);
            check({tag, " pready_to_done"}, 32'(d_at - p_at), 32'd1);
            check({tag, " tvalid_after_accept"}, 32'(tv_late), 32'd0);
            check({tag, " cmd"}, {o_wr, o_ps, 8'(o_ad), o_wd}, {e_wr, e_ps, 8'(e_ad), e_wd});
        end

        $display("txn %-10s winner=%0d wr=%0b psel=%0b addr=0x%0h wdata=0x%0h delay=%0d -> done=%b err=%0b rdata=0x%0h",
                 tag, w, e_wr, e_ps, e_ad, e_wd, delay, o_done, o_err, o_rd);

        // Requester drops its request before the edge ending DONE
        bus.req_valid[w] = 1'b0;
        @(negedge pclk);
        check({tag, " idle_gap_busy"}, 32'(bus.busy), 32'd0);
        check({tag, " done_pulse_len"}, 32'(bus.req_done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_psel  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        apb_idle();

        // ---- Reset state ----
        repeat (2) @(negedge pclk);
        check("reset busy",     32'(bus.busy),     32'd0);
        check("reset t_valid",  32'(bus.t_valid),  32'd0);
        check("reset req_done", 32'(bus.req_done), 32'd0);
        check("reset req_err",  32'(bus.req_err),  32'd0);
        check("reset rdata",    32'(bus.rdata),    32'd0);
        check("reset grant_id", 32'(bus.grant_id), 32'd0);
        check("reset cmd", {bus.pwrite_in, bus.psel_in, 8'(bus.paddr_in), bus.pwdata_in}, 32'd0);
        prst = 1'b1;
        @(negedge pclk);

        // ---- Single write, requester 2, zero wait states ----
        set_req(2, 1'b1, 2'b01, 4'h3, 16'hBEEF);
        bus.req_valid = 4'b0100;
        do_txn("wr_r2", 0, 16'h5555, 1'b0);

        // ---- Read, requester 1, pready delayed 3 cycles ----
        set_req(1, 1'b0, 2'b10, 4'h7, 16'h0000);
        bus.req_valid = 4'b0010;
        do_txn("rd_r1", 3, 16'h1234, 1'b0);

        // ---- Requester 3 with no slave selected ----
        set_req(3, 1'b0, 2'b00, 4'h1, 16'h0000);
        bus.req_valid = 4'b1000;
        do_txn("err_r3", 0, 16'hAAAA, 1'b0);

        // ---- All four requesting continuously ----
        for (int i = 0; i < 4; i++) set_req(i, i[0], 2'(i % 3 + 1), 4'(i + 8), 16'(16'hC000 + i));
        for (int r = 0; r < 5; r++) begin
            bus.req_valid = 4'b1111;
            do_txn($sformatf("all4_%0d", r), r % 2, 16'(16'h4000 + r), 1'b0);
        end

        // ---- Reset while waiting for pready ----
        bus.req_valid = 4'b0000;
        set_req(1, 1'b0, 2'b10, 4'h2, 16'h0000);
        bus.req_valid = 4'b0010;
        begin
            bit tv;
            tv = 0;
            for (int n = 0; n < 8 && !tv; n++) begin
                @(negedge pclk);
                tv = bus.t_valid;
            end
            check("rst_wait reach_issue", 32'(tv), 32'd1);
        end
        bus.m_ready = 1'b1; bus.penable = 1'b1; bus.pready = 1'b0; bus.prdata = 16'h9999;
        @(negedge pclk);
        bus.m_ready = 1'b0;
        check("rst_wait in_wait busy", 32'(bus.busy), 32'd1);
        #2 prst = 1'b0;
        #1;
        check("rst_wait busy",    32'(bus.busy),     32'd0);
        check("rst_wait t_valid", 32'(bus.t_valid),  32'd0);
        check("rst_wait outs", {bus.req_done, 1'(bus.req_err), bus.grant_id, bus.rdata}, 32'd0);
        check("rst_wait cmd", {bus.pwrite_in, bus.psel_in, 8'(bus.paddr_in), bus.pwdata_in}, 32'd0);
        bus.pready = 1'b1;
        bus.req_valid = 4'b0011;
        set_req(0, 1'b1, 2'b11, 4'h5, 16'h0A0A);
        repeat (2) begin
            @(negedge pclk);
            check("rst_hold no_done", 32'(bus.req_done), 32'd0);
        end
        apb_idle();
        prst  = 1'b1;
        m_ptr = 3;
        m_rdata = '0;
        $display("txn rst_wait   reset applied in WAIT, requests 0 and 1 pending");
        do_txn("post_rst", 1, 16'h0BAD, 1'b0);
        check("post_rst winner0", 32'(m_ptr), 32'd0);

        // ---- Randomized rounds ----
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 4; i++)
                set_req(i, 1'($urandom), 2'($urandom), AW'($urandom), DW'($urandom));
            bus.req_valid = 4'($urandom_range(1, 15));
            do_txn($sformatf("rnd_%0d", t), $urandom_range(0, 3), DW'($urandom), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
